// File: rtl/nbit_mult_pkg.sv
// Shared types and constants for the sequential shift-add / Booth multiplier.
package nbit_mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Booth pair {Q[0], q(-1)}; 2'b11 is also a no-op
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Bits needed to hold values 0..value-1, never less than 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      bits++;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/mult_step_cell.sv
// One multiplier iteration: add/sub/nop of M into A, then right shift of {A, Q, q(-1)}.
module mult_step_cell
  import nbit_mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] qReg,
  input  logic             qm1,
  input  logic [WIDTH-1:0] mcand,
  input  logic             signedMode,
  output logic [WIDTH-1:0] accNext,
  output logic [WIDTH-1:0] qNext,
  output logic             qm1Next
);

  // Sum carries one extra bit: the carry (unsigned) or the sign (Booth)
  logic [WIDTH:0] sum;

  if (SIGNED_EN) begin : gBooth
    logic [1:0]     pair;
    logic [1:0]     op;
    logic [WIDTH:0] aExt;
    logic [WIDTH:0] mExt;

    always_comb begin
      pair = {qReg[0], qm1};
      aExt = {signedMode & acc[WIDTH-1], acc};
      mExt = {signedMode & mcand[WIDTH-1], mcand};
      op   = BOOTH_NOP;
      if (signedMode) begin
        if (pair == BOOTH_ADD || pair == BOOTH_SUB) op = pair;
      end else if (qReg[0]) begin
        op = BOOTH_ADD;
      end
      case (op)
        BOOTH_ADD: sum = aExt + mExt;
        BOOTH_SUB: sum = aExt - mExt;
        default:   sum = aExt;
      endcase
    end
  end else begin : gShiftAdd
    assign sum = qReg[0] ? ({1'b0, acc} + {1'b0, mcand}) : {1'b0, acc};
  end

  // The top sum bit is the shift-in for both logical (carry) and arithmetic (sign) shifts
  assign accNext = sum[WIDTH:1];
  assign qNext   = {sum[0], qReg[WIDTH-1:1]};
  assign qm1Next = qReg[0];

endmodule

// File: rtl/nbit_seq_multiplier.sv
// Sequential N-bit multiplier: one shift-add or Booth step per clock, WIDTH cycles per product.
module nbit_seq_multiplier
  import nbit_mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signedMode,
  output logic               ready,
  output logic               busy,
  output logic               resultValid,
  input  logic               resultReady,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned     CntW    = clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e             stateQ, stateD;
  logic [CntW-1:0]    cntQ;
  logic [WIDTH-1:0]   accQ, qRegQ, mcandQ;
  logic               qm1Q, modeQ;
  logic [2*WIDTH-1:0] productQ;

  logic [WIDTH-1:0]   accNext, qNext;
  logic               qm1Next;
  logic               accept;

  assign accept = start & ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: if (accept) stateD = StRun;
      StRun:  if (cntQ == '0) stateD = StDone;
      // Consuming with start pending reloads immediately, no idle bubble
      StDone: if (resultReady) stateD = start ? StRun : StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    busy        = 1'b0;
    resultValid = 1'b0;
    unique case (stateQ)
      StIdle: ready = 1'b1;
      StRun:  busy = 1'b1;
      StDone: begin
        resultValid = 1'b1;
        ready       = resultReady;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cntQ     <= '0;
      accQ     <= '0;
      qRegQ    <= '0;
      mcandQ   <= '0;
      qm1Q     <= 1'b0;
      modeQ    <= 1'b0;
      productQ <= '0;
    end else if (accept) begin
      cntQ   <= LastCnt;
      accQ   <= '0;
      qRegQ  <= multiplier;
      mcandQ <= multiplicand;
      qm1Q   <= 1'b0;
      modeQ  <= signedMode & SIGNED_EN;
    end else if (stateQ == StRun) begin
      accQ  <= accNext;
      qRegQ <= qNext;
      qm1Q  <= qm1Next;
      if (cntQ == '0) begin
        productQ <= {accNext, qNext};
      end else begin
        cntQ <= cntQ - 1'b1;
      end
    end
  end

  mult_step_cell #(
    .WIDTH     (WIDTH),
    .SIGNED_EN (SIGNED_EN)
  ) uStep (
    .acc        (accQ),
    .qReg       (qRegQ),
    .qm1        (qm1Q),
    .mcand      (mcandQ),
    .signedMode (modeQ),
    .accNext    (accNext),
    .qNext      (qNext),
    .qm1Next    (qm1Next)
  );

  assign product = productQ;

endmodule

// File: tb/tb_nbit_seq_multiplier.sv
// Self-checking bench: directed vectors, random W=8 runs, handshake corners, exhaustive W=4.
module tb_nbit_seq_multiplier;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic        start8, sm8, rr8, ready8, busy8, rv8;
  logic [7:0]  m8, q8;
  logic [15:0] p8;

  // Both W=4 instances share inputs and run in lockstep
  logic       start4, sm4, rr4, readyS, busyS, rvS, readyU, busyU, rvU;
  logic [3:0] m4, q4;
  logic [7:0] pS, pU;

  nbit_seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .multiplicand(m8), .multiplier(q8),
    .signedMode(sm8), .ready(ready8), .busy(busy8), .resultValid(rv8),
    .resultReady(rr8), .product(p8)
  );

  nbit_seq_multiplier #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4s (
    .clock(clock), .reset(reset), .start(start4), .multiplicand(m4), .multiplier(q4),
    .signedMode(sm4), .ready(readyS), .busy(busyS), .resultValid(rvS),
    .resultReady(rr4), .product(pS)
  );

  nbit_seq_multiplier #(.WIDTH(4), .SIGNED_EN(1'b0)) dut4u (
    .clock(clock), .reset(reset), .start(start4), .multiplicand(m4), .multiplier(q4),
    .signedMode(sm4), .ready(readyU), .busy(busyU), .resultValid(rvU),
    .resultReady(rr4), .product(pU)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiply, operands reinterpreted as two's complement when signed
  function automatic longint refMul(input int w, input longint m, input longint q, input bit s);
    longint a, b;
    a = m;
    b = q;
    if (s) begin
      if (((a >> (w - 1)) & 1) != 0) a = a - (longint'(1) << w);
      if (((b >> (w - 1)) & 1) != 0) b = b - (longint'(1) << w);
    end
    return (a * b) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic waitValid8(output int lat);
    lat = 0;
    while (!rv8 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // One W=8 transaction; lat counts edges after acceptance until resultValid
  task automatic run8(input logic [7:0] m, input logic [7:0] q, input bit s,
                      output logic [15:0] p, output int lat, output bit runOk);
    @(negedge clock);
    start8 = 1'b1; m8 = m; q8 = q; sm8 = s; rr8 = 1'b0;
    @(negedge clock);
    start8 = 1'b0;
    runOk  = busy8 && !ready8 && !rv8;
    m8 = 8'($urandom); q8 = 8'($urandom); sm8 = ~s;
    waitValid8(lat);
    p = p8;
    rr8 = 1'b1;
    @(negedge clock);
    rr8 = 1'b0;
  endtask

  task automatic run4(input logic [3:0] m, input logic [3:0] q, input bit s,
                      output logic [7:0] ps, output logic [7:0] pu);
    int n;
    @(negedge clock);
    start4 = 1'b1; m4 = m; q4 = q; sm4 = s; rr4 = 1'b0;
    @(negedge clock);
    start4 = 1'b0;
    n = 0;
    while (!(rvS && rvU) && n < 20) begin
      @(negedge clock);
      n++;
    end
    ps = pS;
    pu = pU;
    rr4 = 1'b1;
    @(negedge clock);
    rr4 = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    bit          s;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] p;
    logic [7:0]  ps, pu;
    logic [7:0]  rm, rq;
    bit          rs, ok;
    int          lat;

    vecs = '{
      '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
      '{8'h80, 8'h80, 1'b1, 16'h4000},
      '{8'hFD, 8'h05, 1'b1, 16'hFFF1},
      '{8'h00, 8'h00, 1'b0, 16'h0000},
      '{8'h01, 8'hFF, 1'b1, 16'hFFFF},
      '{8'h7F, 8'h80, 1'b1, 16'hC080},
      '{8'hFF, 8'hFF, 1'b1, 16'h0001},
      '{8'h80, 8'h7F, 1'b0, 16'h3F80}
    };

    reset = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; rr8 = 1'b0; m8 = '0; q8 = '0;
    start4 = 1'b0; sm4 = 1'b0; rr4 = 1'b0; m4 = '0; q4 = '0;
    repeat (2) @(negedge clock);
    check("reset busy", 64'(busy8), 64'd0);
    check("reset valid", 64'(rv8), 64'd0);
    check("reset product", 64'(p8), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post-reset ready", 64'(ready8), 64'd1);

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].m, vecs[i].q, vecs[i].s, p, lat, ok);
      check($sformatf("vec%0d product", i), 64'(p), 64'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd8);
      check($sformatf("vec%0d busy/ready in run", i), 64'(ok), 64'd1);
    end

    for (int i = 0; i < 30; i++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      run8(rm, rq, rs, p, lat, ok);
      check($sformatf("rand %0h*%0h s=%0d", rm, rq, rs), 64'(p), 64'(refMul(8, rm, rq, rs)));
    end

    // Back-to-back: start in the DONE cycle while consuming
    @(negedge clock);
    start8 = 1'b1; m8 = 8'd5; q8 = 8'd6; sm8 = 1'b0; rr8 = 1'b0;
    @(negedge clock);
    start8 = 1'b0;
    waitValid8(lat);
    check("b2b first product", 64'(p8), 64'd30);
    rr8 = 1'b1; start8 = 1'b1; m8 = 8'd7; q8 = 8'd9;
    @(negedge clock);
    start8 = 1'b0; rr8 = 1'b0;
    check("b2b no bubble busy", 64'(busy8), 64'd1);
    check("b2b valid dropped", 64'(rv8), 64'd0);
    waitValid8(lat);
    check("b2b latency", 64'(lat), 64'd8);
    check("b2b second product", 64'(p8), 64'd63);
    rr8 = 1'b1;
    @(negedge clock);
    rr8 = 1'b0;

    // Backpressure: product held, start ignored
    @(negedge clock);
    start8 = 1'b1; m8 = 8'd20; q8 = 8'd3; sm8 = 1'b0;
    @(negedge clock);
    start8 = 1'b0;
    waitValid8(lat);
    for (int i = 0; i < 5; i++) begin
      start8 = 1'b1; m8 = 8'd99; q8 = 8'd99; rr8 = 1'b0;
      @(negedge clock);
      check($sformatf("bp%0d valid held", i), 64'(rv8), 64'd1);
      check($sformatf("bp%0d product held", i), 64'(p8), 64'd60);
    end
    start8 = 1'b0; rr8 = 1'b1;
    @(negedge clock);
    rr8 = 1'b0;
    check("bp consumed valid", 64'(rv8), 64'd0);
    check("bp consumed ready", 64'(ready8), 64'd1);
    run8(8'd11, 8'd13, 1'b0, p, lat, ok);
    check("bp later pair", 64'(p), 64'd143);

    // Reset mid-RUN discards the in-flight product asynchronously
    @(negedge clock);
    start8 = 1'b1; m8 = 8'd200; q8 = 8'd200; sm8 = 1'b0;
    @(negedge clock);
    start8 = 1'b0;
    repeat (4) @(negedge clock);
    check("mid-run busy before reset", 64'(busy8), 64'd1);
    reset = 1'b1;
    #1;
    check("mid-run reset valid", 64'(rv8), 64'd0);
    check("mid-run reset busy", 64'(busy8), 64'd0);
    check("mid-run reset product", 64'(p8), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid-run release ready", 64'(ready8), 64'd1);
    run8(8'd12, 8'd10, 1'b0, p, lat, ok);
    check("after reset 12*10", 64'(p), 64'd120);
    check("after reset latency", 64'(lat), 64'd8);

    // Exhaustive W=4: signed-capable and unsigned-only instances
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          run4(4'(a), 4'(b), 1'(s), ps, pu);
          check($sformatf("w4 signedEn %0h*%0h s=%0d", a, b, s), 64'(ps),
                64'(refMul(4, a, b, 1'(s))));
          check($sformatf("w4 unsignedOnly %0h*%0h s=%0d", a, b, s), 64'(pu),
                64'(refMul(4, a, b, 1'b0)));
        end
      end
    end
    run4(4'hF, 4'hF, 1'b1, ps, pu);
    check("w4 SIGNED_EN=0 F*F mode=1", 64'(pu), 64'd225);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
